spi_slave: RTL and testbench

SPI peripheral-side (slave) controller with a 32-bit register-bus interface. It is the counterpart to the `spi` master: the master drives SCK/MOSI/CS, and this block shifts out a CPU-supplied byte while receiving one. It lets an on-chip CPU act as an SPI device and gives the master a loop-back partner in system benches. SPI inputs are asynchronous and are oversampled on the system clock.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_sync.sv | 33 +++
 rtl/spi_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register map and frame constants for the SPI slave
package spi_pkg;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_adr_e;

  localparam int STAT_RXVALID  = 0;
  localparam int STAT_TXFULL   = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_UNDERRUN = 3;
  localparam int STAT_BUSY     = 4;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;

  localparam int FRAME_BITS = 8;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - two-flop synchronizer for one asynchronous input
// Ports: clk_i/rst_i clock and async active-high reset, d_i async input,
//        q_o synchronized output. RST_VAL is the idle level held in reset.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave with 32-bit register bus
// Ports: clk_i/rst_i system clock and async active-high reset;
//        adr_i/sel_i/stb_i/we_i/dat_i/dat_o/ack_o register bus (ack registered);
//        spiClk_i/spiMosi_i/spiCs_i async SPI inputs, spiMiso_o MISO (always driven);
//        irq_o interrupt, present only when SPI_SLAVE_IRQ_EN is defined.
module spi_slave
  import spi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:2]  adr_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        spiClk_i,
  input  logic        spiMosi_i,
  input  logic        spiCs_i,
  output logic        spiMiso_o
`ifdef SPI_SLAVE_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam logic [3:0] CNT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] CNT_FULL = 4'(FRAME_BITS);

  logic sck_s, mosi_s, cs_s;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sck  (.clk_i(clk_i), .rst_i(rst_i), .d_i(spiClk_i),  .q_o(sck_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(clk_i), .rst_i(rst_i), .d_i(spiMosi_i), .q_o(mosi_s));
  // CS idles high, so its synchronizer resets to the idle level to avoid a fake BUSY.
  spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk_i(clk_i), .rst_i(rst_i), .d_i(spiCs_i),   .q_o(cs_s));

  logic        sck_prev_q, sck_prev_d;
  logic        cs_prev_q, cs_prev_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        txfull_q, txfull_d;
  logic        rxvalid_q, rxvalid_d;
  logic        overrun_q, overrun_d;
  logic        underrun_q, underrun_d;
  logic        en_q, en_d;
  logic        irqen_q, irqen_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic       spi_on, access, wr, rd, pop, done, load;
  logic [7:0] rx_byte;
  reg_adr_e   adr;

  logic unused_bits;
  assign unused_bits = ^{sel_i[3:1], dat_i[31:8]};

  always_comb begin
    adr      = reg_adr_e'(adr_i);
    sck_rise = sck_s & ~sck_prev_q;
    sck_fall = ~sck_s & sck_prev_q;
    cs_rise  = cs_s & ~cs_prev_q;
    cs_fall  = ~cs_s & cs_prev_q;
    spi_on   = en_q & ~cs_s;
    access   = stb_i & ~ack_q;
    wr       = access & we_i & sel_i[0];
    rd       = access & ~we_i;
    pop      = rd & (adr == REG_RXDATA);
    rx_byte  = {rx_shift_q[6:0], mosi_s};
    done     = spi_on & sck_rise & (cnt_q == CNT_LAST);
    // The fall following the last rise of a byte preloads the next byte.
    load     = spi_on & (cs_fall | (sck_fall & (cnt_q == CNT_FULL)));
  end

  always_comb begin
    sck_prev_d = sck_s;
    cs_prev_d  = cs_s;
    tx_hold_d  = tx_hold_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    txfull_d   = txfull_q;
    rxvalid_d  = rxvalid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    en_d       = en_q;
    irqen_d    = irqen_q;
    ack_d      = access;
    dat_d      = '0;

    if (rd) begin
      case (adr)
        REG_RXDATA: dat_d[7:0] = rx_data_q;
        REG_STATUS: begin
          dat_d[STAT_RXVALID]  = rxvalid_q;
          dat_d[STAT_TXFULL]   = txfull_q;
          dat_d[STAT_OVERRUN]  = overrun_q;
          dat_d[STAT_UNDERRUN] = underrun_q;
          dat_d[STAT_BUSY]     = ~cs_s;
        end
        REG_CTRL: begin
          dat_d[CTRL_EN]    = en_q;
          dat_d[CTRL_IRQEN] = irqen_q;
        end
        default: dat_d = '0;
      endcase
    end

    // Bus-side clears go first so same-cycle hardware events still set the flags.
    if (wr && adr == REG_STATUS) begin
      if (dat_i[STAT_OVERRUN])  overrun_d  = 1'b0;
      if (dat_i[STAT_UNDERRUN]) underrun_d = 1'b0;
    end
    if (wr && adr == REG_CTRL) begin
      en_d = dat_i[CTRL_EN];
`ifdef SPI_SLAVE_IRQ_EN
      irqen_d = dat_i[CTRL_IRQEN];
`endif
    end
    if (pop) rxvalid_d = 1'b0;

    if (cs_rise) begin
      cnt_d      = '0;
      rx_shift_d = '0;
    end else if (spi_on) begin
      if (cs_fall) cnt_d = '0;
      if (sck_rise) begin
        rx_shift_d = rx_byte;
        cnt_d      = cnt_q + 4'd1;
      end else if (sck_fall) begin
        if (cnt_q == CNT_FULL) cnt_d = '0;
        else tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
    end
    if (!en_q) cnt_d = '0;

    if (load) begin
      tx_shift_d = txfull_q ? tx_hold_q : 8'h00;
      txfull_d   = 1'b0;
      if (!txfull_q) underrun_d = 1'b1;
    end

    // A write landing with a load refills the now-empty holding register.
    if (wr && adr == REG_TXDATA) begin
      tx_hold_d = dat_i[7:0];
      txfull_d  = 1'b1;
    end

    // A pop in the completion cycle frees RXDATA for the new byte.
    if (done) begin
      if (!rxvalid_q || pop) begin
        rx_data_d = rx_byte;
        rxvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      txfull_q   <= 1'b0;
      rxvalid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      en_q       <= 1'b0;
      irqen_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      sck_prev_q <= sck_prev_d;
      cs_prev_q  <= cs_prev_d;
      tx_hold_q  <= tx_hold_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      txfull_q   <= txfull_d;
      rxvalid_q  <= rxvalid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      en_q       <= en_d;
      irqen_q    <= irqen_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign ack_o     = ack_q;
  assign dat_o     = dat_q;
  assign spiMiso_o = tx_shift_q[7] & spi_on;

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irqen_q & (rxvalid_q | overrun_q | underrun_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave against a frame-level model
module tb_spi_slave;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = 2'd0;
  logic [3:0]  sel = 4'hF;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        ack;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        miso;
`ifdef SPI_SLAVE_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  spi_slave dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .sel_i(sel), .stb_i(stb), .we_i(we),
    .dat_i(wdat), .dat_o(rdat), .ack_o(ack),
    .spiClk_i(sck), .spiMosi_i(mosi), .spiCs_i(cs), .spiMiso_o(miso)
`ifdef SPI_SLAVE_IRQ_EN
    , .irq_o(irq)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // frame-level reference state
  logic [7:0] m_hold, m_rx;
  bit m_txfull, m_rxvalid, m_ovr, m_und, m_en, m_irqen, m_busy;
  logic [7:0] mo [4];
  logic [7:0] tcur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_hold = '0; m_rx = '0;
    m_txfull = 0; m_rxvalid = 0; m_ovr = 0; m_und = 0;
    m_en = 0; m_irqen = 0; m_busy = 0;
  endtask

  function automatic logic [31:0] m_status();
    return {27'b0, m_busy, m_und, m_ovr, m_txfull, m_rxvalid};
  endfunction

  // byte presented on MISO for the next frame slot
  task automatic m_load(output logic [7:0] v);
    v = 8'h00;
    if (m_en) begin
      if (m_txfull) begin
        v = m_hold;
        m_txfull = 0;
      end else begin
        m_und = 1;
      end
    end
  endtask

  task automatic m_complete(input logic [7:0] b);
    if (m_en) begin
      if (!m_rxvalid) begin
        m_rx = b;
        m_rxvalid = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    int n;
    adr = a; we = 1'b1; wdat = d; stb = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    check("wr_ack", 32'(ack), 32'd1);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("wr_ack_pulse", 32'(ack), 32'd0);
    case (a)
      2'd0: begin m_hold = d[7:0]; m_txfull = 1; end
      2'd2: begin
        if (d[2]) m_ovr = 0;
        if (d[3]) m_und = 0;
      end
      2'd3: begin
        m_en = d[0];
`ifdef SPI_SLAVE_IRQ_EN
        m_irqen = d[1];
`endif
      end
      default: ;
    endcase
  endtask

  task automatic read_chk(input logic [1:0] a, input string tag);
    logic [31:0] exp;
    int n;
    case (a)
      2'd1:    exp = {24'b0, m_rx};
      2'd2:    exp = m_status();
      2'd3:    exp = {30'b0, m_irqen, m_en};
      default: exp = '0;
    endcase
    adr = a; we = 1'b0; stb = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check(tag, rdat, exp);
    stb = 1'b0;
    @(negedge clk);
    if (a == 2'd1) m_rxvalid = 0;
  endtask

  // Master side: mode 0, MSB first. SCK is left high at the end of the final
  // full byte, CS is raised, then SCK returns low while deselected.
  task automatic spi_frame(input int nbytes, input int last_bits, input bit pop_last);
    logic [7:0] cur, got;
    int nb;
    bit last;
    nb = 8;
    cs = 1'b0; mosi = mo[0][7];
    m_load(cur);
    half();
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : 8;
      got = '0;
      for (int i = 0; i < nb; i++) begin
        got = {got[6:0], miso};
        sck = 1'b1;
        last = (b == nbytes - 1) && (i == nb - 1);
        if (last && pop_last && nb == 8) begin
          // RXDATA read timed to ack on the same edge the byte completes
          repeat (2) @(negedge clk);
          adr = 2'd1; we = 1'b0; stb = 1'b1;
          @(negedge clk);
          check("pop_ack", 32'(ack), 32'd1);
          check("pop_data", rdat, {24'b0, m_rx});
          stb = 1'b0;
          m_rxvalid = 0;
          repeat (HALF - 3) @(negedge clk);
        end else begin
          half();
        end
        if (i == 7) begin
          check($sformatf("miso_byte%0d", b), 32'(got), 32'(cur));
          m_complete(mo[b]);
          if (!last) m_load(cur);
        end
        if (!last) begin
          sck = 1'b0;
          mosi = (i < nb - 1) ? mo[b][6 - i] : mo[b + 1][7];
          half();
        end
      end
    end
    if (nb == 8) begin
      cs = 1'b1; half(); sck = 1'b0; half();
    end else begin
      sck = 1'b0; half(); cs = 1'b1; half();
    end
  endtask

  initial begin
    logic [31:0] r;
    int nbytes;
    m_reset();

    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", rdat, 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
`ifdef SPI_SLAVE_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    read_chk(2'd2, "rst_status");
    read_chk(2'd3, "rst_ctrl");
    read_chk(2'd1, "rst_rxdata");

    // basic exchange
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'hA5);
    read_chk(2'd0, "txdata_reads0");
    read_chk(2'd2, "status_txfull");
    mo[0] = 8'h3C;
    spi_frame(1, 8, 0);
    read_chk(2'd1, "rx_3c");
    read_chk(2'd2, "status_idle");

    // back-to-back with only one byte loaded
    bus_write(2'd0, 32'h11);
    mo[0] = 8'h96; mo[1] = 8'h69;
    spi_frame(2, 8, 0);
    read_chk(2'd2, "status_underrun");
    bus_write(2'd2, 32'h08);
    read_chk(2'd2, "status_und_clr");
    read_chk(2'd1, "rx_first_kept");
    bus_write(2'd2, 32'h04);

    // overrun, then the same with a completion-cycle pop
    bus_write(2'd0, 32'h77);
    mo[0] = 8'h01; mo[1] = 8'h02;
    spi_frame(2, 8, 0);
    read_chk(2'd2, "status_overrun");
    read_chk(2'd1, "rx_overrun_01");
    bus_write(2'd2, 32'h0C);
    bus_write(2'd0, 32'h77);
    spi_frame(2, 8, 1);
    read_chk(2'd2, "status_pop_race");
    read_chk(2'd1, "rx_pop_02");
    bus_write(2'd2, 32'h0C);

    // partial byte aborted by CS, then a full byte
    bus_write(2'd0, 32'h33);
    mo[0] = 8'hF0;
    spi_frame(1, 4, 0);
    read_chk(2'd2, "status_partial");
    bus_write(2'd0, 32'h44);
    mo[0] = 8'h5A;
    spi_frame(1, 8, 0);
    read_chk(2'd1, "rx_5a");
    read_chk(2'd2, "status_after_5a");

    // reset in the middle of a byte
    bus_write(2'd0, 32'hFF);
    cs = 1'b0; mosi = 1'b1;
    m_load(tcur);
    half();
    m_busy = 1;
    read_chk(2'd2, "status_busy");
    m_busy = 0;
    sck = 1'b1;
    half();
    check("miso_pre_rst", 32'(miso), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_dat", rdat, 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    m_reset();
    @(negedge clk);
    cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    half();
    read_chk(2'd2, "postrst_status");
    read_chk(2'd3, "postrst_ctrl");
    bus_write(2'd3, 32'd1);
    bus_write(2'd0, 32'h2B);
    mo[0] = 8'hC3;
    spi_frame(1, 8, 0);
    read_chk(2'd1, "rx_c3");

`ifdef SPI_SLAVE_IRQ_EN
    bus_write(2'd3, 32'd3);
    read_chk(2'd3, "ctrl_irqen");
    bus_write(2'd0, 32'h5E);
    check("irq_idle", 32'(irq), 32'd0);
    mo[0] = 8'hE7;
    spi_frame(1, 8, 0);
    check("irq_set", 32'(irq), 32'd1);
    read_chk(2'd1, "irq_rx");
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);
`endif

    // randomized frames against the model
    for (int it = 0; it < 24; it++) begin
      r = $urandom;
      bus_write(2'd3, {30'b0, r[1], (r[3:2] != 2'b00)});
      read_chk(2'd3, "rand_ctrl");
      if (r[4] | r[5]) bus_write(2'd0, $urandom);
      if (r[6]) read_chk(2'd1, "rand_pre_rx");
      nbytes = 1 + int'(r[9:8]) % 3;
      for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
      spi_frame(nbytes, 8, 0);
      read_chk(2'd2, "rand_status");
      if (r[7]) bus_write(2'd2, {28'b0, r[13:10]});
      read_chk(2'd1, "rand_rx");
      read_chk(2'd2, "rand_status_post");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
